// File: rtl/spi_reg_ctrl_pkg.sv
// Shared constants for the SPI command/register controller: state encoding,
// command byte layout and address helpers.
package spi_ctrl_pkg;

  localparam int ADDR_W = 6;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR_DATA = 2'd1;
  localparam logic [1:0] RD_DATA = 2'd2;

  localparam int CMD_RW       = 7;
  localparam int CMD_BURST    = 6;
  localparam int CMD_ADDR_MSB = 5;

  function automatic logic addr_ok(input addr_t a, input int nregs);
    return int'(a) < nregs;
  endfunction

  // 6-bit increment, then wrap to zero when the result lands on nregs
  function automatic addr_t addr_inc(input addr_t a, input int nregs);
    addr_t n;
    n = a + addr_t'(1);
    if (int'(n) == nregs) n = '0;
    return n;
  endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-level link between the SPI slave datapath and the register controller.
interface spi_reg_ctrl_if;
  logic [7:0] rx_byte;
  logic       rx_flag;
  logic [7:0] tx_byte;

  modport master (output rx_byte, output rx_flag, input  tx_byte);
  modport slave  (input  rx_byte, input  rx_flag, output tx_byte);
endinterface

// File: rtl/spi_reg_ctrl_regfile.sv
// NREGS x 8 configuration register bank with one write port, a combinational
// read mux (zero when out of range) and a flattened view of all registers.
module spi_regfile
  import spi_ctrl_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               we,
  input  addr_t              waddr,
  input  logic [7:0]         wdata,
  input  addr_t              raddr,
  output logic [7:0]         rdata,
  output logic [8*NREGS-1:0] cfg_out
);

  logic [8*NREGS-1:0] regs_q;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      regs_q <= '0;
    end else if (we) begin
      for (int i = 0; i < NREGS; i++) begin
        if (waddr == addr_t'(i)) regs_q[8*i +: 8] <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (raddr == addr_t'(i)) rdata = regs_q[8*i +: 8];
    end
  end

  assign cfg_out = regs_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Interprets SPI frames as command/data bytes, sequences register writes and
// reads, and abandons open transactions after TIMEOUT frame-free cycles.
module spi_reg_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int         NREGS   = 16,
  parameter int         TIMEOUT = 100000,
  parameter logic [7:0] IDLE_TX = 8'hA5
) (
  input  logic               clock,
  input  logic               rst,
  spi_reg_ctrl_if.slave      spi,
  output logic [8*NREGS-1:0] cfg_out,
  output logic               wr_strobe,
  output logic [5:0]         wr_addr,
  output logic               rd_strobe,
  output logic               busy,
  output logic               err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]       state;
  addr_t            addr;
  logic             burst;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       tx_q;

  addr_t      cmd_addr;
  addr_t      addr_nxt;
  addr_t      rd_addr;
  logic       rd_ok;
  logic [7:0] rdata;
  logic       wr_en;
  logic       timeout;

  // In IDLE the read port looks at the incoming command so the first read
  // byte is ready one cycle after the command frame; otherwise it looks ahead.
  assign cmd_addr = spi.rx_byte[CMD_ADDR_MSB:0];
  assign addr_nxt = addr_inc(addr, NREGS);
  assign rd_addr  = (state == IDLE) ? cmd_addr : addr_nxt;
  assign rd_ok    = addr_ok(rd_addr, NREGS);
  assign wr_en    = (state == WR_DATA) && spi.rx_flag && addr_ok(addr, NREGS);
  assign timeout  = (state != IDLE) && !spi.rx_flag && (cnt == CNT_W'(TIMEOUT - 1));

  spi_regfile #(.NREGS(NREGS)) u_regfile (
    .clock   (clock),
    .rst     (rst),
    .we      (wr_en),
    .waddr   (addr),
    .wdata   (spi.rx_byte),
    .raddr   (rd_addr),
    .rdata   (rdata),
    .cfg_out (cfg_out)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr      <= '0;
      burst     <= 1'b0;
      cnt       <= '0;
      tx_q      <= IDLE_TX;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      rd_strobe <= 1'b0;
      err       <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;

      if (spi.rx_flag || timeout || state == IDLE) cnt <= '0;
      else                                         cnt <= cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (spi.rx_flag) begin
            addr  <= cmd_addr;
            burst <= spi.rx_byte[CMD_BURST];
            if (spi.rx_byte[CMD_RW]) begin
              state <= RD_DATA;
              tx_q  <= rdata;
              if (rd_ok) rd_strobe <= 1'b1;
              else       err       <= 1'b1;
            end else begin
              state <= WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (spi.rx_flag) begin
            if (wr_en) begin
              wr_strobe <= 1'b1;
              wr_addr   <= addr;
            end else begin
              err <= 1'b1;
            end
            if (burst) addr  <= addr_nxt;
            else       state <= IDLE;
          end else if (timeout) begin
            state <= IDLE;
            tx_q  <= IDLE_TX;
          end
        end
        RD_DATA: begin
          // The frame that just ended carried the read byte out; its rx_byte is junk.
          if (spi.rx_flag) begin
            if (burst) begin
              addr <= addr_nxt;
              tx_q <= rdata;
              if (rd_ok) rd_strobe <= 1'b1;
              else       err       <= 1'b1;
            end else begin
              tx_q  <= IDLE_TX;
              state <= IDLE;
            end
          end else if (timeout) begin
            state <= IDLE;
            tx_q  <= IDLE_TX;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign spi.tx_byte = tx_q;
  assign busy        = (state != IDLE);

endmodule
